// File: rtl/ram_loader_pkg.sv
// Shared types and defaults for the RAM loader and its checksum accumulators.
// Holds the FSM state encoding, width defaults and the RAM read latency.
package ram_loader_pkg;

    localparam int ADDR_W_DEF = 15;
    localparam int LEN_W_DEF  = 16;
    localparam int RAM_RD_LAT = 1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WRITE   = 3'd1,
        ST_RD_ADDR = 3'd2,
        ST_RD_DATA = 3'd3,
        ST_FINISH  = 3'd4
    } state_t;

    function automatic logic [7:0] cksum_add(input logic [7:0] a, input logic [7:0] b);
        return a + b;
    endfunction

endpackage

// File: rtl/ram_loader_cksum.sv
// 8-bit additive checksum accumulator: clear wins over add, sum visible the cycle after.
// No backpressure; o_eq compares the running sum against i_cmp combinationally.
module ram_loader_cksum
    import ram_loader_pkg::*;
(
    input  logic       i_clock,
    input  logic       i_reset_n,
    input  logic       i_clr,
    input  logic       i_add,
    input  logic [7:0] i_data,
    input  logic [7:0] i_cmp,
    output logic [7:0] o_sum,
    output logic       o_eq
);

    logic [7:0] r_sum;

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_sum <= 8'h00;
        end else if (i_clr) begin
            r_sum <= 8'h00;
        end else if (i_add) begin
            r_sum <= cksum_add(r_sum, i_data);
        end
    end

    assign o_sum = r_sum;
    assign o_eq  = (r_sum == i_cmp);

endmodule

// File: rtl/ram_loader.sv
// Streams bytes into consecutive RAM addresses, then optionally reads them back and checks the sum.
// Write lands one cycle after each accepted beat; s_ready stays high until the last byte is taken.
module ram_loader
    import ram_loader_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int LEN_W  = LEN_W_DEF,
    parameter int VERIFY = 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  length,
    input  logic              s_valid,
    input  logic [7:0]        s_data,
    output logic              s_ready,
    output logic [ADDR_W-1:0] mem_address,
    output logic [7:0]        mem_data_out,
    output logic              mem_ce,
    output logic              mem_rden,
    output logic              mem_wren,
    input  logic [7:0]        mem_q,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [7:0]        checksum
);

    state_t            r_state;
    logic [ADDR_W-1:0] r_base;
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W-1:0] r_addr;
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W-1:0]  r_remain;
    logic [7:0]        r_wdat;
    logic              r_s_ready;
    logic              r_ce;
    logic              r_rden;
    logic              r_wren;
    logic              r_busy;
    logic              r_done;
    logic              r_error;

    logic              w_start_acc;
    logic              w_beat;
    logic              w_write_end;
    logic              w_vsum_clr;
    logic              w_vsum_add;
    logic [7:0]        w_wsum;
    logic [7:0]        w_vsum;
    logic              w_weq;
    logic              w_veq;

    assign w_start_acc = start && (r_state == ST_IDLE);
    assign w_beat      = s_valid && r_s_ready;
    assign w_write_end = (r_state == ST_WRITE) && (r_remain == '0);
    assign w_vsum_clr  = w_start_acc || w_write_end;
    assign w_vsum_add  = (r_state == ST_RD_DATA);

    ram_loader_cksum u_wsum (
        .i_clock   (clock),
        .i_reset_n (reset_n),
        .i_clr     (w_start_acc),
        .i_add     (w_beat),
        .i_data    (s_data),
        .i_cmp     (w_vsum),
        .o_sum     (w_wsum),
        .o_eq      (w_weq)
    );

    ram_loader_cksum u_vsum (
        .i_clock   (clock),
        .i_reset_n (reset_n),
        .i_clr     (w_vsum_clr),
        .i_add     (w_vsum_add),
        .i_data    (mem_q),
        .i_cmp     (w_wsum),
        .o_sum     (w_vsum),
        .o_eq      (w_veq)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_IDLE;
            r_base    <= '0;
            r_ptr     <= '0;
            r_addr    <= '0;
            r_len     <= '0;
            r_remain  <= '0;
            r_wdat    <= 8'h00;
            r_s_ready <= 1'b0;
            r_ce      <= 1'b0;
            r_rden    <= 1'b0;
            r_wren    <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_error   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_ce   <= 1'b0;
                    r_wren <= 1'b0;
                    r_rden <= 1'b0;
                    if (start) begin
                        r_base    <= base_addr;
                        r_ptr     <= base_addr;
                        r_len     <= length;
                        r_remain  <= length;
                        r_busy    <= 1'b1;
                        r_error   <= 1'b0;
                        r_s_ready <= (length != '0);
                        r_state   <= (length == '0) ? ST_FINISH : ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (w_beat) begin
                        r_ce      <= 1'b1;
                        r_wren    <= 1'b1;
                        r_addr    <= r_ptr;
                        r_wdat    <= s_data;
                        r_ptr     <= r_ptr + ADDR_W'(1);
                        r_remain  <= r_remain - LEN_W'(1);
                        r_s_ready <= (r_remain != LEN_W'(1));
                    end else begin
                        r_ce   <= 1'b0;
                        r_wren <= 1'b0;
                    end
                    // remain==0 here means the final write is on the bus this cycle
                    if (r_remain == '0) begin
                        if (VERIFY != 0) begin
                            r_state  <= ST_RD_ADDR;
                            r_ptr    <= r_base;
                            r_remain <= r_len;
                            r_addr   <= r_base;
                            r_ce     <= 1'b1;
                            r_rden   <= 1'b1;
                        end else begin
                            r_state <= ST_FINISH;
                        end
                    end
                end
                ST_RD_ADDR: begin
                    r_state <= ST_RD_DATA;
                end
                ST_RD_DATA: begin
                    r_ptr    <= r_ptr + ADDR_W'(1);
                    r_remain <= r_remain - LEN_W'(1);
                    if (r_remain == LEN_W'(1)) begin
                        r_state <= ST_FINISH;
                        r_ce    <= 1'b0;
                        r_rden  <= 1'b0;
                    end else begin
                        r_state <= ST_RD_ADDR;
                        r_addr  <= r_ptr + ADDR_W'(1);
                    end
                end
                ST_FINISH: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_error <= (VERIFY != 0) && !(w_weq && w_veq);
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign s_ready      = r_s_ready;
    assign mem_address  = r_addr;
    assign mem_data_out = r_wdat;
    assign mem_ce       = r_ce;
    assign mem_rden     = r_rden;
    assign mem_wren     = r_wren;
    assign busy         = r_busy;
    assign done         = r_done;
    assign error        = r_error;
    assign checksum     = w_wsum;

    a_len_legal: assert property (@(posedge clock) disable iff (!reset_n)
        (start && r_state == ST_IDLE) |-> (32'(length) <= (32'd1 << ADDR_W)));

    a_rd_latency: assert property (@(posedge clock) disable iff (!reset_n)
        (r_state == ST_RD_DATA) |-> ($past(r_state, RAM_RD_LAT) == ST_RD_ADDR));

endmodule

// File: tb/tb_ram_loader.sv
// Scoreboard bench: driver pushes expected writes, reads and completions; a negedge monitor checks them.
module tb_ram_loader;

    localparam int AW   = 15;
    localparam int LW   = 16;
    localparam int CORR = 32'h0102;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [LW-1:0] length;
    logic          s_valid;
    logic [7:0]    s_data;
    logic          s_ready;
    logic [AW-1:0] mem_address;
    logic [7:0]    mem_data_out;
    logic          mem_ce;
    logic          mem_rden;
    logic          mem_wren;
    logic [7:0]    mem_q;
    logic          busy;
    logic          done;
    logic          error;
    logic [7:0]    checksum;

    int checks = 0;
    int errors = 0;
    int wq[$];
    int rq[$];
    int cq[$];
    int mon_e;
    bit prev_beat;
    bit corrupt_en;
    logic [7:0] ram [0:32767];
    logic [7:0] ram_q;
    logic [7:0] pdat [0:63];

    always #5 clock = ~clock;

    ram_loader #(.ADDR_W(AW), .LEN_W(LW), .VERIFY(1)) dut (
        .clock(clock), .reset_n(reset_n), .start(start), .base_addr(base_addr),
        .length(length), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .mem_address(mem_address), .mem_data_out(mem_data_out), .mem_ce(mem_ce),
        .mem_rden(mem_rden), .mem_wren(mem_wren), .mem_q(mem_q), .busy(busy),
        .done(done), .error(error), .checksum(checksum)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Synchronous RAM with one-clock read latency; optional stuck byte at CORR.
    always @(posedge clock) begin
        if (mem_ce && mem_wren)
            ram[mem_address] <= (corrupt_en && 32'(mem_address) == CORR) ? 8'h34 : mem_data_out;
        if (mem_ce && mem_rden)
            ram_q <= ram[mem_address];
    end
    assign mem_q = ram_q;

    always @(negedge clock) begin
        if (!reset_n) begin
            prev_beat = 1'b0;
        end else begin
            chk("wren_follows_beat", 32'(mem_wren), 32'(prev_beat));
            chk("wren_rden_exclusive", 32'(mem_wren & mem_rden), 0);
            chk("ce_iff_enable", 32'(mem_ce), 32'(mem_wren | mem_rden));
            if (mem_wren) begin
                if (wq.size() == 0) chk("unexpected_write", 1, 0);
                else begin
                    mon_e = wq.pop_front();
                    chk("wr_addr", 32'(mem_address), 32'(mon_e >> 8));
                    chk("wr_data", 32'(mem_data_out), 32'(mon_e & 255));
                end
            end
            if (mem_rden) begin
                if (rq.size() == 0) chk("unexpected_read", 1, 0);
                else begin
                    mon_e = rq.pop_front();
                    chk("rd_addr", 32'(mem_address), 32'(mon_e));
                end
            end
            if (done) begin
                if (cq.size() == 0) chk("unexpected_done", 1, 0);
                else begin
                    mon_e = cq.pop_front();
                    chk("done_checksum", 32'(checksum), 32'(mon_e & 255));
                    chk("done_error", 32'(error), 32'((mon_e >> 8) & 1));
                    chk("done_busy_low", 32'(busy), 0);
                    chk("writes_all_seen", 32'(wq.size()), 0);
                    chk("reads_all_seen", 32'(rq.size()), 0);
                end
            end
            prev_beat = s_valid & s_ready;
        end
    end

    task automatic push_expect(input int base, input int len, output int sum);
        int a;
        int rs;
        sum = 0;
        rs  = 0;
        for (int i = 0; i < len; i++) begin
            a = (base + i) % 32768;
            wq.push_back((a << 8) | int'(pdat[i]));
            rq.push_back(a);
            rq.push_back(a);
            sum = (sum + int'(pdat[i])) % 256;
            rs  = (rs + ((corrupt_en && a == CORR) ? 32'h34 : int'(pdat[i]))) % 256;
        end
        cq.push_back(((rs != sum) ? 256 : 0) | sum);
    endtask

    task automatic pulse_start(input int base, input int len);
        start     = 1'b1;
        base_addr = AW'(base);
        length    = LW'(len);
        @(posedge clock); #1;
        start = 1'b0;
        @(negedge clock);
        chk("busy_after_start", 32'(busy), 1);
        chk("cksum_cleared", 32'(checksum), 0);
        chk("error_cleared", 32'(error), 0);
        @(posedge clock); #1;
    endtask

    task automatic send(input int n, input int gap, input int glitch_at);
        int g;
        int tries;
        bit acc;
        for (int i = 0; i < n; i++) begin
            g = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
            s_valid = 1'b0;
            repeat (g) begin @(posedge clock); #1; end
            s_valid = 1'b1;
            s_data  = pdat[i];
            if (i == glitch_at) begin
                start     = 1'b1;
                base_addr = AW'($urandom_range(0, 32767));
                length    = LW'($urandom_range(1, 9));
            end
            acc   = 1'b0;
            tries = 0;
            while (!acc && tries < 100) begin
                @(negedge clock);
                acc = s_ready;
                @(posedge clock); #1;
                start = 1'b0;
                tries++;
            end
            if (!acc) chk("s_ready_timeout", 0, 1);
        end
        s_valid = 1'b0;
    endtask

    task automatic run_xfer(input int base, input int len, input int gap, input int glitch_at, input bit corrupt);
        int sum;
        int cyc;
        corrupt_en = corrupt;
        push_expect(base, len, sum);
        pulse_start(base, len);
        send(len, gap, glitch_at);
        cyc = 0;
        while (!done && cyc < 3000) begin @(posedge clock); #1; cyc++; end
        chk("done_seen", 32'(done), 1);
        if (len == 0) chk("len0_done_latency", cyc, 0);
        repeat (3) @(negedge clock);
        chk("cksum_held", 32'(checksum), 32'(sum));
        chk("idle_s_ready_low", 32'(s_ready), 0);
        @(posedge clock); #1;
        corrupt_en = 1'b0;
    endtask

    task automatic load_abcd();
        pdat[0] = 8'h11; pdat[1] = 8'h22; pdat[2] = 8'h33; pdat[3] = 8'h44;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_outputs"}, {17'(0), s_ready, mem_ce, mem_rden, mem_wren, busy, done, error, checksum}, 0);
        chk({tag, "_mem_bus"}, {9'(0), mem_address, mem_data_out}, 0);
    endtask

    initial begin
        int len;
        int base;
        bit corr;
        reset_n = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = 8'h00;
        base_addr = '0; length = '0; corrupt_en = 1'b0;
        #2 reset_n = 1'b0;
        #1 check_all_zero("reset");
        repeat (3) @(posedge clock); #1 reset_n = 1'b1;
        @(posedge clock); #1;

        // abort after 3 of 8 bytes
        for (int i = 0; i < 8; i++) pdat[i] = 8'($urandom);
        begin
            int s;
            push_expect(32'h0200, 8, s);
        end
        pulse_start(32'h0200, 8);
        send(3, 0, -1);
        reset_n = 1'b0;
        #1 check_all_zero("mid_reset");
        wq.delete(); rq.delete(); cq.delete();
        repeat (3) @(posedge clock); #1 reset_n = 1'b1;
        repeat (4) @(negedge clock);
        chk("no_done_after_reset", 32'(done | busy), 0);
        @(posedge clock); #1;

        load_abcd();
        run_xfer(32'h0100, 4, 0, -1, 1'b0);
        chk("directed_cksum_AA", 32'(checksum), 32'hAA);
        chk("directed_error0", 32'(error), 0);

        run_xfer(32'h0100, 4, 2, -1, 1'b0);
        chk("gap_cksum_AA", 32'(checksum), 32'hAA);

        pdat[0] = 8'hFF; pdat[1] = 8'h01;
        run_xfer(32'h7FFF, 2, 0, -1, 1'b0);
        chk("wrap_cksum_00", 32'(checksum), 0);
        chk("wrap_error0", 32'(error), 0);

        run_xfer(0, 0, 0, -1, 1'b0);

        load_abcd();
        run_xfer(32'h0100, 4, 0, -1, 1'b1);
        chk("corrupt_error1", 32'(error), 1);
        chk("corrupt_cksum_AA", 32'(checksum), 32'hAA);

        run_xfer(32'h0100, 4, 1, 2, 1'b0);
        chk("glitch_cksum_AA", 32'(checksum), 32'hAA);

        for (int t = 0; t < 12; t++) begin
            len  = int'($urandom_range(0, 24));
            corr = ($urandom_range(0, 3) == 0);
            if (corr) base = 32'h0100 - int'($urandom_range(0, 8));
            else if (t % 4 == 3) base = 32767 - int'($urandom_range(0, 5));
            else base = int'($urandom_range(0, 32767));
            for (int i = 0; i < len; i++) pdat[i] = 8'($urandom);
            run_xfer(base, len, (t % 2 == 0) ? -1 : 0, (t % 3 == 0) ? int'($urandom_range(0, 24)) : -1, corr);
        end

        chk("final_queues_empty", 32'(wq.size() + rq.size() + cq.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ram_loader.md
Name: ram_loader

Overview:
- Bus initiator that drives the RAM wrapper's ce/rden/wren/address/data_in port.
- Accepts a byte stream on a valid/ready handshake and writes it to consecutive RAM addresses starting at a base address.
- Optionally reads the block back and compares an 8-bit additive checksum.
- Sits between the boot/serial download path and the 32 KB system RAM, and owns the RAM port while busy.

Parameters:
- ADDR_W, 15, RAM address width; addresses wrap modulo 2^ADDR_W.
- LEN_W, 16, transfer length width; legal length range is 0..2^ADDR_W.
- VERIFY, 1, when 1 run the read-back checksum phase; when 0 skip it.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; latches base_addr/length when idle.
- base_addr  in  ADDR_W  first RAM address.
- length  in  LEN_W  number of bytes to load.
- s_valid  in  1  stream byte valid.
- s_data  in  8  stream byte.
- s_ready  out  1  loader accepts byte this cycle.
- mem_address  out  ADDR_W  RAM address.
- mem_data_out  out  8  RAM write data.
- mem_ce  out  1  RAM chip enable.
- mem_rden  out  1  RAM read enable.
- mem_wren  out  1  RAM write enable.
- mem_q  in  8  RAM read data; high-Z unless ce&rden.
- busy  out  1  high from the cycle after accepted start until done.
- done  out  1  one-cycle completion pulse.
- error  out  1  checksum mismatch; held until next accepted start.
- checksum  out  8  sum mod 256 of bytes written; held after done.

Behaviour:
- Reset values: all outputs 0 and mem_address 0. Asynchronous assert, synchronous deassert expected upstream. Reset mid-transfer aborts immediately with no done pulse; RAM contents are undefined.
- All outputs are registered.
- States are IDLE, WRITE, RD_ADDR, RD_DATA, FINISH.
- IDLE: start=1 latches base_addr into the address pointer and length into a remaining counter, clears checksum/error, and moves to WRITE. If length==0, go straight to FINISH. start while busy is ignored.
- WRITE:
  - s_ready=1 while remaining>0.
  - Beat = s_valid&s_ready in cycle n. In cycle n+1: mem_ce=1, mem_wren=1, mem_rden=0, mem_data_out=byte, mem_address=pointer.
  - Pointer increments mod 2^ADDR_W; remaining decrements; checksum += byte (8-bit wrap).
  - Throughput is one byte per cycle; s_valid gaps give mem_wren=0 and mem_ce=0.
  - When the last beat is accepted, s_ready drops the next cycle. After the final write cycle, go to RD_ADDR if VERIFY=1, else FINISH.
- Verify phase:
  - Pointer reloads base_addr and remaining reloads length; a verify sum is cleared.
  - RD_ADDR: mem_ce=1, mem_rden=1, address=pointer (RAM latency is one clock).
  - RD_DATA: hold the same ce/rden/address; sample mem_q at the end of this cycle and add it to the verify sum. Pointer increments; go back to RD_ADDR, or to FINISH after the last byte.
  - Result: 2 cycles per byte.
- FINISH: lasts one cycle. done=1 and busy=0. error is set if VERIFY=1 and verify sum != checksum. Then IDLE.
- mem_wren and mem_rden are never high together. mem_ce=0 whenever both are low.
- Address wrap: base=0x7FFF, length=2 writes 0x7FFF then 0x0000.
- length > 2^ADDR_W is illegal and must be covered by an assertion only.

Decomposition:
- Shared package:
  - state encoding constants.
  - ADDR_W/LEN_W defaults.
  - RAM read latency constant (1).
- One natural sub-module: ram_loader_cksum, an 8-bit accumulator with clear/add/compare, instanced twice (write sum, verify sum).

Test Plan:
- Reset during WRITE after 3 of 8 bytes -> all outputs 0 immediately; no done; a subsequent start works normally.
- start, base=0x0100, len=4, bytes 11,22,33,44 back-to-back, VERIFY=1 -> wren at 0x0100..0x0103 on consecutive cycles; 8 read cycles; done with checksum=0xAA, error=0.
- Same transfer with s_valid gaps of 2 cycles between bytes -> wren only on cycles following beats; same final checksum.
- base=0x7FFF, len=2, bytes FF,01 -> writes at 0x7FFF then 0x0000; checksum=0x00; verify passes.
- len=0 -> done one cycle after busy; no mem_ce; checksum=0.
- Bench RAM model corrupts address 0x0102 to 0x34 before verify -> done with error=1; checksum still 0xAA.
- start pulsed mid-transfer -> ignored; original transfer completes unchanged.
